// File: rtl/ram_sync_pkg.sv
// ram_sync_pkg: shared FSM states, r_w encoding and parity helper for ram_sync_param
package ram_sync_pkg;
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/ram_sync_param_if.sv
// ram_sync_param_if: request/ready bus between a master and ram_sync_param
interface ram_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int ADDR_W = 2
);
  logic req;
  logic r_w;
  logic fill;
  logic ready;
  logic valid;
  logic perr;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  modport master(output req, r_w, addr, in, fill, input ready, out, valid, perr);
  modport slave(input req, r_w, addr, in, fill, output ready, out, valid, perr);
endinterface

// File: rtl/ram_sync_array.sv
// ram_sync_array: WIDTH x DEPTH storage, one write port, registered read port (optional parity via RAM_SYNC_PARITY_EN)
module ram_sync_array
  import ram_sync_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              rerr
);
`ifdef RAM_SYNC_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L = AW1'(DEPTH);
  logic [WIDTH+PW-1:0] mem [DEPTH];
  logic [WIDTH+PW-1:0] wword;
  logic [WIDTH+PW-1:0] word;
  logic w_ok, r_ok, bad;
  assign w_ok = {1'b0, waddr} < DEPTH_L;
  assign r_ok = {1'b0, raddr} < DEPTH_L;
  assign word = mem[raddr];
`ifdef RAM_SYNC_PARITY_EN
  assign wword = {even_par(64'(wdata)), wdata};
  assign bad = even_par(64'(word[WIDTH-1:0])) != word[WIDTH];
`else
  assign wword = wdata;
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk)
    if (we && w_ok) mem[waddr] <= wword;
  // out-of-range reads return zero rather than stale or undefined storage
  always_ff @(posedge clk)
    if (rst) begin
      rdata <= '0;
      rerr <= 1'b0;
    end else if (re) begin
      rdata <= r_ok ? word[WIDTH-1:0] : '0;
      rerr <= r_ok & bad;
    end
endmodule

// File: rtl/ram_sync_param.sv
// ram_sync_param: handshaked synchronous RAM with init sweep; parity checking enabled by RAM_SYNC_PARITY_EN
module ram_sync_param
  import ram_sync_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic clk,
  input logic clear,
  ram_sync_param_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] idx, waddr;
  logic [WIDTH-1:0] wdata, rdata;
  logic sweep, accept, we, re, valid, rerr;
  assign sweep = state == ST_INIT;
  assign accept = bus.req & bus.ready & ~bus.fill;
  assign we = sweep | (accept & (bus.r_w == RW_WRITE));
  assign re = accept & (bus.r_w == RW_READ);
  assign waddr = sweep ? idx : bus.addr;
  assign wdata = sweep ? INIT_VAL : bus.in;
  assign bus.ready = state == ST_IDLE;
  assign bus.valid = valid;
  assign bus.out = rdata;
  assign bus.perr = valid & rerr;
  // fill restarts the sweep from any state
  always_comb state_nx = bus.fill ? ST_INIT : (sweep && idx == LAST) ? ST_IDLE : state;
  always_ff @(posedge clk)
    if (clear) begin
      state <= ST_INIT;
      idx <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= (bus.fill || !sweep || idx == LAST) ? '0 : idx + 1'b1;
      valid <= re;
    end
  ram_sync_array #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_array (
    .clk(clk),
    .rst(clear),
    .we(we),
    .re(re),
    .waddr(waddr),
    .raddr(bus.addr),
    .wdata(wdata),
    .rdata(rdata),
    .rerr(rerr)
  );
endmodule

// File: tb/tb_ram_sync_param.sv
// tb_ram_sync_param: randomized check of two ram_sync_param instances against a word-array model
module tb_ram_sync_param;
  logic clk = 1'b0;
  logic clear_a = 1'b0;
  logic clear_b = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mem [2][8];
  bit pbad [2][8];
  int busy [2] = '{0, 0};
  logic [7:0] exp_o [2] = '{8'h00, 8'h00};
  bit exp_v [2] = '{0, 0};
  bit exp_p [2] = '{0, 0};
  ram_sync_param_if #(.WIDTH(8), .ADDR_W(2)) a_if ();
  ram_sync_param_if #(.WIDTH(8), .ADDR_W(3)) b_if ();
  ram_sync_param #(.WIDTH(8), .DEPTH(4)) dut_a (.clk(clk), .clear(clear_a), .bus(a_if));
  ram_sync_param #(.WIDTH(8), .DEPTH(5), .INIT_VAL(8'h5A)) dut_b (.clk(clk), .clear(clear_b), .bus(b_if));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input int s, input bit rq, input bit rw, input int a, input logic [7:0] d,
                     input bit fl, input bit clr);
    logic rdy, vld, pe;
    logic [7:0] o;
    bit acc;
    int dep;
    dep = s == 1 ? 5 : 4;
    if (s == 1) begin
      b_if.req = rq; b_if.r_w = rw; b_if.addr = 3'(a); b_if.in = d; b_if.fill = fl; clear_b = clr;
      rdy = b_if.ready;
    end else begin
      a_if.req = rq; a_if.r_w = rw; a_if.addr = 2'(a); a_if.in = d; a_if.fill = fl; clear_a = clr;
      rdy = a_if.ready;
    end
    if (!clr) check($sformatf("ready%0d", s), 32'(rdy), 32'(busy[s] == 0));
    acc = rq && busy[s] == 0 && !fl && !clr;
    exp_v[s] = 0;
    if (clr || fl) begin
      busy[s] = dep;
      for (int i = 0; i < 8; i++) begin
        mem[s][i] = s == 1 ? 8'h5A : 8'h00;
        pbad[s][i] = 0;
      end
      if (clr) exp_o[s] = 8'h00;
    end else begin
      if (busy[s] > 0) busy[s]--;
      if (acc && rw && a < dep) begin
        mem[s][a] = d;
        pbad[s][a] = 0;
      end
      if (acc && !rw) begin
        exp_v[s] = 1;
        exp_o[s] = a < dep ? mem[s][a] : 8'h00;
        exp_p[s] = a < dep && pbad[s][a];
      end
    end
    @(posedge clk);
    #1;
    vld = s == 1 ? b_if.valid : a_if.valid;
    o = s == 1 ? b_if.out : a_if.out;
    pe = s == 1 ? b_if.perr : a_if.perr;
    check($sformatf("valid%0d", s), 32'(vld), 32'(exp_v[s]));
    check($sformatf("out%0d", s), 32'(o), 32'(exp_o[s]));
    check($sformatf("perr%0d", s), 32'(pe), 32'(exp_v[s] & exp_p[s]));
  endtask
  task automatic wr(input int s, input int a, input logic [7:0] d);
    cyc(s, 1, 1, a, d, 0, 0);
  endtask
  task automatic rd(input int s, input int a);
    cyc(s, 1, 0, a, 8'h00, 0, 0);
  endtask
  task automatic idle(input int s, input int n);
    for (int i = 0; i < n; i++) cyc(s, 0, 0, 0, 8'h00, 0, 0);
  endtask
  task automatic rnd(input int s, input int n);
    for (int i = 0; i < n; i++)
      cyc(s, 1'($urandom), 1'($urandom), int'($urandom_range(0, s == 1 ? 7 : 3)), 8'($urandom),
          $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0);
  endtask
  initial begin
    a_if.req = 0; a_if.r_w = 0; a_if.addr = '0; a_if.in = '0; a_if.fill = 0;
    b_if.req = 0; b_if.r_w = 0; b_if.addr = '0; b_if.in = '0; b_if.fill = 0;
    #2;
    cyc(0, 0, 0, 0, 8'h00, 0, 1);
    idle(0, 4);
    for (int i = 0; i < 4; i++) begin
      rd(0, i);
      idle(0, 1);
    end
    wr(0, 0, 8'h03);
    wr(0, 1, 8'h09);
    rd(0, 0);
    rd(0, 1);
    idle(0, 1);
    wr(0, 2, 8'hA5);
    rd(0, 2);
    rd(0, 3);
    cyc(0, 1, 1, 0, 8'hFF, 1, 0);
    idle(0, 4);
    rd(0, 0);
    cyc(0, 0, 0, 0, 8'h00, 0, 1);
    idle(0, 1);
    cyc(0, 0, 0, 0, 8'h00, 0, 1);
    idle(0, 4);
    wr(0, 3, 8'h77);
    rd(0, 3);
    cyc(0, 0, 0, 0, 8'h00, 0, 1);
    idle(0, 4);
`ifdef RAM_SYNC_PARITY_EN
    wr(0, 1, 8'h0F);
    dut_a.u_array.mem[1][0] = ~dut_a.u_array.mem[1][0];
    pbad[0][1] = 1;
    rd(0, 1);
    rd(0, 0);
    idle(0, 1);
`endif
    rnd(0, 400);
    cyc(1, 0, 0, 0, 8'h00, 0, 1);
    idle(1, 5);
    rd(1, 4);
    wr(1, 6, 8'h11);
    rd(1, 6);
    wr(1, 4, 8'hC3);
    rd(1, 4);
    rd(1, 7);
    rnd(1, 400);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
